// File: rtl/ecl_lock_controller_pkg.sv
// Shared state encoding, digit constants and sizing helper for the combination lock controller.
package ecl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    PROG    = 3'd4,
    LOCKOUT = 3'd5
  } state_t;

  localparam logic DIGIT_0 = 1'b0;
  localparam logic DIGIT_1 = 1'b1;

  // One timer serves every timed state, so size it for the longest interval.
  function automatic int timerWidth(input int unlockCyc, input int lockoutCyc, input int idleToCyc);
    int m;
    int w;
    m = unlockCyc;
    if (lockoutCyc > m) m = lockoutCyc;
    if (idleToCyc > m) m = idleToCyc;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ecl_lock_controller_if.sv
// Button strobes in, actuator and status LEDs out, for the combination lock controller.
interface ecl_lock_controller_if;

  logic       but_0;
  logic       but_1;
  logic       prog_req;
  logic       UNLOCK;
  logic       LOCKED_OUT;
  logic       PROG_MODE;
  logic [3:0] FAIL_CNT;

  modport master (
    output but_0, but_1, prog_req,
    input  UNLOCK, LOCKED_OUT, PROG_MODE, FAIL_CNT
  );

  modport slave (
    input  but_0, but_1, prog_req,
    output UNLOCK, LOCKED_OUT, PROG_MODE, FAIL_CNT
  );

endinterface

// File: rtl/ecl_lock_controller_digit_shifter.sv
// Entry shift register and digit counter, shared by normal code entry and reprogramming.
module ecl_digit_shifter #(
  parameter int CODE_LEN = 5
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                clear_i,
  input  logic                shift_i,
  input  logic                digit_i,
  output logic [CODE_LEN-1:0] entry_o,
  output logic [CODE_LEN-1:0] nextEntry_o,
  output logic                full_o
);

  localparam int CW = $clog2(CODE_LEN + 1);

  logic [CODE_LEN-1:0] entry_q;
  logic [CW-1:0]       count_q;

  // full_o flags that the next shift completes the code, so the controller can act on that same press.
  assign nextEntry_o = (entry_q << 1) | CODE_LEN'(digit_i);
  assign full_o      = (count_q == CW'(CODE_LEN - 1));
  assign entry_o     = entry_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      entry_q <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      entry_q <= '0;
      count_q <= '0;
    end else if (shift_i) begin
      entry_q <= nextEntry_o;
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/ecl_lock_controller.sv
// Combination lock sequencer: digit entry, code check, timed unlock/lockout and reprogramming.
module ecl_lock_controller
  import ecl_pkg::*;
#(
  parameter int                  CODE_LEN     = 5,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE = 5'b01011,
  parameter int                  MAX_FAIL     = 3,
  parameter int                  UNLOCK_CYC   = 500,
  parameter int                  LOCKOUT_CYC  = 1000,
  parameter int                  IDLE_TO_CYC  = 200
) (
  input logic CLK,
  input logic RESET,
  ecl_lock_controller_if.slave bus
);

  localparam int TW = timerWidth(UNLOCK_CYC, LOCKOUT_CYC, IDLE_TO_CYC);

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [3:0]          failCnt_q, failCnt_d;
  logic [CODE_LEN-1:0] code_q;
  logic                press, digit, clear, shift, loadCode, full, pressRestart;
  logic [CODE_LEN-1:0] entry, nextEntry;

  assign press = bus.but_0 ^ bus.but_1;
  assign digit = bus.but_1 ? DIGIT_1 : DIGIT_0;

  ecl_digit_shifter #(.CODE_LEN(CODE_LEN)) u_shifter (
    .CLK         (CLK),
    .RESET       (RESET),
    .clear_i     (clear),
    .shift_i     (shift),
    .digit_i     (digit),
    .entry_o     (entry),
    .nextEntry_o (nextEntry),
    .full_o      (full)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      timer_q   <= '0;
      failCnt_q <= '0;
      code_q    <= DEFAULT_CODE;
    end else begin
      timer_q   <= timer_d;
      failCnt_q <= failCnt_d;
      if (loadCode) code_q <= nextEntry;
    end
  end

  always_comb begin
    state_d      = state_q;
    failCnt_d    = failCnt_q;
    shift        = 1'b0;
    loadCode     = 1'b0;
    pressRestart = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) begin
          shift   = 1'b1;
          state_d = full ? CHECK : ENTRY;
        end
      end
      ENTRY: begin
        if (press) begin
          shift        = 1'b1;
          pressRestart = 1'b1;
          if (full) state_d = CHECK;
        end else if (timer_q == TW'(IDLE_TO_CYC - 1)) begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (entry == code_q) begin
          state_d   = OPEN;
          failCnt_d = '0;
        end else begin
          failCnt_d = (failCnt_q < 4'(MAX_FAIL)) ? failCnt_q + 4'd1 : 4'(MAX_FAIL);
          state_d   = (failCnt_d == 4'(MAX_FAIL)) ? LOCKOUT : IDLE;
        end
      end
      OPEN: begin
        if (bus.prog_req) begin
          state_d = PROG;
        end else if (timer_q == TW'(UNLOCK_CYC - 1)) begin
          state_d = IDLE;
        end
      end
      PROG: begin
        if (press) begin
          shift        = 1'b1;
          pressRestart = 1'b1;
          if (full) begin
            loadCode = 1'b1;
            state_d  = IDLE;
          end
        end else if (timer_q == TW'(IDLE_TO_CYC - 1)) begin
          state_d = IDLE;
        end
      end
      LOCKOUT: begin
        if (timer_q == TW'(LOCKOUT_CYC - 1)) begin
          state_d   = IDLE;
          failCnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entering PROG must also wipe the shifter, since a successful check leaves the old entry in it.
  always_comb begin
    clear   = (state_d != state_q) && ((state_d == IDLE) || (state_d == PROG));
    timer_d = ((state_d != state_q) || pressRestart) ? '0 : timer_q + TW'(1);
  end

  always_comb begin
    bus.UNLOCK     = (state_q == OPEN);
    bus.LOCKED_OUT = (state_q == LOCKOUT);
    bus.PROG_MODE  = (state_q == PROG);
    bus.FAIL_CNT   = failCnt_q;
  end

endmodule

// File: doc/ecl_lock_controller.md
Name: ecl_lock_controller

Overview:
Sequencing controller for the electronic combination lock. It collects button digits into an entry register and compares the entry against a programmable code register. It also manages relocking, failed-attempt counting with a timed lockout, inactivity abort, and code reprogramming while open. It sits between the synchronized push-button strobes and the lock actuator / status LEDs.

Parameters:
CODE_LEN, 5, number of digits per code (1..16)
DEFAULT_CODE, 5'b01011, code loaded at reset; first digit entered is the MSB
MAX_FAIL, 3, consecutive mismatches that trigger lockout (1..15)
UNLOCK_CYC, 500, cycles UNLOCK stays high
LOCKOUT_CYC, 1000, cycles LOCKED_OUT stays high
IDLE_TO_CYC, 200, inactivity cycles before a partial entry or programming session is aborted

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
but_0  in  1  digit-0 strobe, already synchronized, one cycle per press
but_1  in  1  digit-1 strobe, already synchronized, one cycle per press
prog_req  in  1  level; request code reprogramming while open
UNLOCK  out  1  lock open
LOCKED_OUT  out  1  lockout active
PROG_MODE  out  1  new-code entry in progress
FAIL_CNT  out  4  consecutive failed attempts

Behaviour:
- Reset: RESET is asynchronous and active-low; CLK is the clock. On reset: state=IDLE, code_reg=DEFAULT_CODE, entry cleared, digit count=0, timer=0, FAIL_CNT=0, UNLOCK=0, LOCKED_OUT=0, PROG_MODE=0. Reset may occur in any state and takes effect immediately. It discards any programmed code.
- Valid press: but_0^but_1==1. The digit value is but_1. Both high, or both low, means no press.
- Outputs are Moore decodes of the registered state. UNLOCK=1 only in OPEN, LOCKED_OUT=1 only in LOCKOUT, PROG_MODE=1 only in PROG.
- Timer: a single counter, cleared on every state change and on every valid press in ENTRY and PROG. Otherwise it increments each cycle.
- States:
  - IDLE: a valid press shifts the digit into the entry register (left shift, LSB in) and sets count=1. Next state is ENTRY, or CHECK if CODE_LEN==1.
  - ENTRY: a valid press shifts the digit and increments count. When count reaches CODE_LEN on that press, go to CHECK. If the timer reaches IDLE_TO_CYC-1 with no press, go to IDLE and clear the entry. FAIL_CNT is unchanged on this abort.
  - CHECK: lasts exactly 1 cycle; presses are ignored.
    - entry==code_reg: go to OPEN and set FAIL_CNT=0.
    - Mismatch: FAIL_CNT+1. If the new value equals MAX_FAIL, go to LOCKOUT; else go to IDLE.
  - OPEN: stays for exactly UNLOCK_CYC cycles, then goes to IDLE. Presses are ignored. If prog_req==1 in any OPEN cycle, go to PROG on the next edge; this takes priority over expiry in the same cycle.
  - PROG: presses collect CODE_LEN digits into the entry register, using the same shift/count rules as ENTRY. On the final digit, code_reg is loaded with the new entry and the next state is IDLE. On inactivity timeout, go to IDLE with code_reg unchanged. prog_req is ignored inside PROG.
  - LOCKOUT: stays for exactly LOCKOUT_CYC cycles, then goes to IDLE with FAIL_CNT=0. Presses are ignored.
- Latency: final digit sampled at edge N → CHECK after edge N → OPEN after edge N+1. UNLOCK is high for cycles N+2 .. N+1+UNLOCK_CYC.
- The entry register and count are cleared on every entry to IDLE.
- FAIL_CNT saturates at MAX_FAIL. It never wraps.

Decomposition:
- Shared package ecl_pkg holds:
  - state enum: IDLE, ENTRY, CHECK, OPEN, PROG, LOCKOUT
  - digit encoding constants
  - timer width function: clog2 of max(UNLOCK_CYC, LOCKOUT_CYC, IDLE_TO_CYC)
- One natural sub-module: ecl_digit_shifter. It holds the entry shift register and digit counter, and provides clear/shift/full outputs. It is reused for both ENTRY and PROG.

Test Plan:
- Reset, then presses 0,1,0,1,1 each separated by 3 idle cycles → UNLOCK=1 starting 2 edges after the last press, for exactly 500 cycles, then 0. FAIL_CNT=0.
- Enter 0,0,0,0,0 three times → FAIL_CNT=1, then 2, then LOCKED_OUT=1 for 1000 cycles. A correct code entered during lockout gives no UNLOCK. After lockout, FAIL_CNT=0 and the correct code unlocks.
- Presses 0,1 then 200 cycles idle → IDLE with FAIL_CNT unchanged. Then 0,1,0,1,1 → UNLOCK=1; a premature CHECK must not occur.
- Unlock, assert prog_req, enter 1,1,0,0,1 → PROG_MODE=1 during entry, then IDLE. Entering 0,1,0,1,1 → FAIL_CNT=1. Entering 1,1,0,0,1 → UNLOCK=1 and FAIL_CNT=0.
- Mid-entry but_0=but_1=1 for one cycle → ignored; count unchanged and the code still unlocks. RESET low during OPEN → UNLOCK=0 immediately and code_reg=01011.
